gfx_wbm_rw_master64: RTL
========================

GFX_WBM_RW_MASTER64 -- requirements
Module: gfx_wbm_rw_master64

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023: bus cycles allowed before a transfer is abandoned (used only with GFX_WBM_TIMEOUT_EN).
REQ-002 SHALL have port clk_i  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_ni  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port read_request_i  in  1  arbitrated read request, held high until ack_o.
REQ-005 SHALL have port write_request_i  in  1  arbitrated write request, held high until ack_o.
REQ-006 SHALL have port addr_i  in  29  [31:3] 64-bit word address.
REQ-007 SHALL have port sel_i  in  8  byte lanes.
REQ-008 SHALL have port dat_i  in  64  write data.
REQ-009 SHALL have port dat_o  out  64  read data, valid when ack_o=1.
REQ-010 SHALL have port ack_o  out  1  one-cycle completion pulse to the arbiter.
REQ-011 SHALL have port err_o  out  1  one-cycle pulse coincident with ack_o when the transfer failed.
REQ-012 SHALL have ports m_wb_cyc_o, m_wb_stb_o, m_wb_we_o  out  1 each  Wishbone master strobes.
REQ-013 SHALL have ports m_wb_adr_o out 32, m_wb_sel_o out 8, m_wb_dat_o out 64, m_wb_cti_o out 3, m_wb_bte_o out 2.
REQ-014 SHALL have ports m_wb_dat_i in 64, m_wb_ack_i in 1, m_wb_err_i in 1.

Function
REQ-015 SHALL implement states IDLE, BUS, DONE.
REQ-016 In IDLE, when read_request_i or write_request_i is high, SHALL latch addr/sel/dat, drive cyc=stb=1 from the next cycle, and enter BUS.
REQ-017 SHALL set m_wb_we_o=1 iff write_request_i was high at latch; both requests high: write wins.
REQ-018 SHALL drive m_wb_adr_o={addr,3'b000}, m_wb_cti_o=3'b000, m_wb_bte_o=2'b00 (classic single cycles only).
REQ-019 SHALL hold all Wishbone outputs stable throughout BUS.
REQ-020 In BUS, on m_wb_ack_i=1: SHALL deassert cyc/stb the next cycle, register m_wb_dat_i into dat_o (reads), pulse ack_o one cycle, enter DONE.
REQ-021 In BUS, on m_wb_err_i=1 (priority over ack): SHALL behave as REQ-020 but pulse err_o with ack_o and drive dat_o=0.
REQ-022 DONE SHALL last exactly one cycle, ignore requests, then return to IDLE (lets the requester drop its request).
REQ-023 Latency: request seen at cycle 0, cyc/stb high at cycle 1; slave ack at cycle k gives ack_o at cycle k+1; earliest next cyc at cycle k+4.
REQ-024 dat_o SHALL hold its value until the next read completes.
REQ-025 Requests arriving in BUS or DONE SHALL NOT alter the transfer in flight.

Reset
REQ-026 rst_ni=0 at a clock edge SHALL force IDLE; cyc, stb, we, ack_o, err_o=0; adr, sel, dat_o, m_wb_dat_o=0, even mid-transfer (transfer abandoned, no ack_o).

Configuration
REQ-027 With GFX_WBM_TIMEOUT_EN defined: SHALL count cycles in BUS; when TIMEOUT_CYCLES cycles pass with no ack/err, SHALL terminate as in REQ-021 (err_o=1).
REQ-028 Without GFX_WBM_TIMEOUT_EN: no counter; BUS waits indefinitely; TIMEOUT_CYCLES ignored.

Structure
REQ-029 SHALL place the state encoding and the Wishbone CTI/BTE classic constants in shared package gfx_wbm_pkg.
REQ-030 SHALL optionally use sub-module gfx_wbm_timeout (counter, load/expire) when GFX_WBM_TIMEOUT_EN is defined; otherwise single module.

Verification
REQ-031 Read: read_request_i=1, addr_i=29'h100, sel_i=8'hFF, slave acks 2 cycles after stb with 64'hDEADBEEF_CAFEF00D -> m_wb_adr_o=32'h800, we=0, ack_o one cycle with dat_o=64'hDEADBEEF_CAFEF00D.
REQ-032 Write: write_request_i=1, dat_i=64'h0123456789ABCDEF, sel_i=8'h0F -> m_wb_we_o=1, dat/sel on bus; ack_o one pulse; no second cycle while request held through DONE.
REQ-033 Error: slave asserts m_wb_err_i -> ack_o and err_o pulse together, dat_o=0, cyc drops next cycle.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=8): slave silent -> cyc drops and ack_o+err_o after 8 BUS cycles; macro off -> cyc stays high for 100+ cycles.
REQ-035 Reset mid-BUS: rst_ni=0 for one edge during cyc=1 -> all outputs 0 next cycle, no ack_o; new request afterwards completes normally.
REQ-036 Both read_request_i and write_request_i high in IDLE -> m_wb_we_o=1.

Source files
------------

// File: rtl/gfx_wbm_pkg.sv
// Shared constants for the 64-bit Wishbone read/write master: FSM encoding,
// classic-cycle CTI/BTE codes, bus widths and the latched request payload.
package gfx_wbm_pkg;

  localparam int unsigned WB_ADR_W   = 32;
  localparam int unsigned WB_DAT_W   = 64;
  localparam int unsigned WB_SEL_W   = 8;
  localparam int unsigned WORD_ADR_W = 29;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  typedef struct packed {
    logic                  we;
    logic [WORD_ADR_W-1:0] adr;
    logic [WB_SEL_W-1:0]   sel;
    logic [WB_DAT_W-1:0]   dat;
  } wb_req_t;

endpackage

// File: rtl/gfx_wbm_timeout.sv
// Bus-cycle watchdog: cleared on load, counts enabled cycles, flags expiry
// on the TIMEOUT_CYCLES-th enabled cycle. Only built with GFX_WBM_TIMEOUT_EN.
module gfx_wbm_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  assign expire_c = en_i && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= '0;
    end else if (en_i && !expire_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gfx_wbm_rw_master64.sv
// Single-transfer 64-bit Wishbone classic master serving one arbitrated
// read/write request at a time. Define GFX_WBM_TIMEOUT_EN to add a bus watchdog.
module gfx_wbm_rw_master64
  import gfx_wbm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  read_request_i,
  input  logic                  write_request_i,
  input  logic [WORD_ADR_W-1:0] addr_i,
  input  logic [WB_SEL_W-1:0]   sel_i,
  input  logic [WB_DAT_W-1:0]   dat_i,
  output logic [WB_DAT_W-1:0]   dat_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic                  m_wb_cyc_o,
  output logic                  m_wb_stb_o,
  output logic                  m_wb_we_o,
  output logic [WB_ADR_W-1:0]   m_wb_adr_o,
  output logic [WB_SEL_W-1:0]   m_wb_sel_o,
  output logic [WB_DAT_W-1:0]   m_wb_dat_o,
  output logic [2:0]            m_wb_cti_o,
  output logic [1:0]            m_wb_bte_o,
  input  logic [WB_DAT_W-1:0]   m_wb_dat_i,
  input  logic                  m_wb_ack_i,
  input  logic                  m_wb_err_i
);

  logic [1:0]          r_state, w_state_nxt;
  wb_req_t             r_req, w_req_nxt;
  logic                r_cyc, w_cyc_nxt;
  logic                r_ack, w_ack_nxt;
  logic                r_err, w_err_nxt;
  logic [WB_DAT_W-1:0] r_dat, w_dat_nxt;
  logic                w_tmo;

`ifdef GFX_WBM_TIMEOUT_EN
  logic w_load;
  logic w_cnt_en;

  assign w_load   = (r_state == ST_IDLE) && (read_request_i || write_request_i);
  assign w_cnt_en = (r_state == ST_BUS) && r_cyc;

  gfx_wbm_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (w_load),
    .en_i    (w_cnt_en),
    .expire_c(w_tmo)
  );
`else
  // No watchdog: the bus waits for the slave indefinitely.
  assign w_tmo = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_cyc_nxt   = r_cyc;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_dat_nxt   = r_dat;
    case (r_state)
      ST_IDLE: begin
        if (read_request_i || write_request_i) begin
          w_req_nxt.we  = write_request_i;
          w_req_nxt.adr = addr_i;
          w_req_nxt.sel = sel_i;
          w_req_nxt.dat = dat_i;
          w_cyc_nxt     = 1'b1;
          w_state_nxt   = ST_BUS;
        end
      end
      ST_BUS: begin
        // ack_o cycle stays in BUS with the bus released, so the next cycle starts no earlier than k+4
        if (r_ack) begin
          w_state_nxt = ST_DONE;
        end else if (m_wb_err_i || w_tmo) begin
          w_cyc_nxt = 1'b0;
          w_ack_nxt = 1'b1;
          w_err_nxt = 1'b1;
          w_dat_nxt = '0;
        end else if (m_wb_ack_i) begin
          w_cyc_nxt = 1'b0;
          w_ack_nxt = 1'b1;
          if (!r_req.we) begin
            w_dat_nxt = m_wb_dat_i;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cyc_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_req   <= '0;
      r_cyc   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_cyc   <= w_cyc_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_dat   <= w_dat_nxt;
    end
  end

  assign dat_o      = r_dat;
  assign ack_o      = r_ack;
  assign err_o      = r_err;
  assign m_wb_cyc_o = r_cyc;
  assign m_wb_stb_o = r_cyc;
  assign m_wb_we_o  = r_req.we;
  assign m_wb_adr_o = {r_req.adr, 3'b000};
  assign m_wb_sel_o = r_req.sel;
  assign m_wb_dat_o = r_req.dat;
  assign m_wb_cti_o = WB_CTI_CLASSIC;
  assign m_wb_bte_o = WB_BTE_LINEAR;

endmodule
